// File: rtl/div_share_ctrl.sv
// div_share_ctrl: two-requester front end for one shared iterative RV32M divider.
// A round-robin arbiter picks one request at a time. The operands are held at the
// divider for the whole operation. The result returns with the requester id and
// tag on a response channel that the consumer can stall.
// Optional feature macro: DIV_SPECIAL_CASE_EN. When it is defined, divide-by-zero
// and signed overflow are resolved at grant time and never reach the divider.
module div_share_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_dividend,
    input  logic [XLEN-1:0]  req0_divisor,
    input  logic [1:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_dividend,
    input  logic [XLEN-1:0]  req1_divisor,
    input  logic [1:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [XLEN-1:0]  rsp_result,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    output logic [1:0]       div_operation,
    output logic             div_valid,
    input  logic [XLEN-1:0]  div_result,
    input  logic             div_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

`ifdef DIV_SPECIAL_CASE_EN
    // Returns {hit, value}. op[1] selects remainder and op[0] selects unsigned.
    function automatic logic [XLEN:0] special_result(input logic [1:0] op,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
        logic [XLEN-1:0] ones;
        logic [XLEN-1:0] min_neg;
        logic            ovf;
        ones    = {XLEN{1'b1}};
        min_neg = {1'b1, {(XLEN-1){1'b0}}};
        ovf     = ~op[0] & (a == min_neg) & (b == ones);
        if (b == {XLEN{1'b0}}) begin
            if (op[1]) return {1'b1, a};
            else       return {1'b1, ones};
        end else if (ovf) begin
            if (op[1]) return {1'b1, {XLEN{1'b0}}};
            else       return {1'b1, min_neg};
        end else begin
            return {1'b0, {XLEN{1'b0}}};
        end
    endfunction
`endif

    state_t           state_q, state_d;
    logic             rr_q, rr_d;             // requester preferred on a tie
    logic             first_wait_q, first_wait_d;
    logic             div_valid_q, div_valid_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic             rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [XLEN-1:0]  rsp_result_q, rsp_result_d;
    logic [XLEN-1:0]  div_dividend_q, div_dividend_d;
    logic [XLEN-1:0]  div_divisor_q, div_divisor_d;
    logic [1:0]       div_operation_q, div_operation_d;

    logic             gnt_any_s;
    logic             gnt_id_s;
    logic [XLEN-1:0]  sel_dividend_s;
    logic [XLEN-1:0]  sel_divisor_s;
    logic [1:0]       sel_op_s;
    logic [TAG_W-1:0] sel_tag_s;
    logic [XLEN:0]    special_s;

    // Arbitration: on a tie the rr pointer decides; otherwise the only valid requester wins.
    always_comb begin
        gnt_any_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id_s = rr_q;
        end else if (req1_valid) begin
            gnt_id_s = 1'b1;
        end else begin
            gnt_id_s = 1'b0;
        end
        if (gnt_id_s) begin
            sel_dividend_s = req1_dividend;
            sel_divisor_s  = req1_divisor;
            sel_op_s       = req1_op;
            sel_tag_s      = req1_tag;
        end else begin
            sel_dividend_s = req0_dividend;
            sel_divisor_s  = req0_divisor;
            sel_op_s       = req0_op;
            sel_tag_s      = req0_tag;
        end
    end

    // Ready can only be asserted in IDLE, and only to the granted requester.
    always_comb begin
        if ((state_q == ST_IDLE) && gnt_any_s) begin
            req0_ready = ~gnt_id_s;
            req1_ready = gnt_id_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Special-case detection on the selected operands. This is constant zero when the feature is off.
    always_comb begin
`ifdef DIV_SPECIAL_CASE_EN
        special_s = special_result(sel_op_s, sel_dividend_s, sel_divisor_s);
`else
        special_s = {(XLEN+1){1'b0}};
`endif
    end

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        first_wait_d    = 1'b0;
        div_valid_d     = 1'b0;
        rsp_valid_d     = rsp_valid_q;
        rsp_id_d        = rsp_id_q;
        rsp_tag_d       = rsp_tag_q;
        rsp_result_d    = rsp_result_q;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        div_operation_d = div_operation_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    rr_d            = ~gnt_id_s;
                    rsp_id_d        = gnt_id_s;
                    rsp_tag_d       = sel_tag_s;
                    div_dividend_d  = sel_dividend_s;
                    div_divisor_d   = sel_divisor_s;
                    div_operation_d = sel_op_s;
                    if (special_s[XLEN]) begin
                        rsp_result_d = special_s[XLEN-1:0];
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        div_valid_d  = 1'b1;
                        state_d      = ST_LAUNCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                first_wait_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // The divider may still show the previous done flag in the first WAIT cycle.
                if (!first_wait_q && div_ready) begin
                    rsp_result_d = div_result;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    state_d      = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs. Reset drops any operation in flight.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            rr_q            <= 1'b0;
            first_wait_q    <= 1'b0;
            div_valid_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            rsp_id_q        <= 1'b0;
            rsp_tag_q       <= {TAG_W{1'b0}};
            rsp_result_q    <= {XLEN{1'b0}};
            div_dividend_q  <= {XLEN{1'b0}};
            div_divisor_q   <= {XLEN{1'b0}};
            div_operation_q <= 2'b00;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            first_wait_q    <= first_wait_d;
            div_valid_q     <= div_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            busy_q          <= busy_d;
            rsp_id_q        <= rsp_id_d;
            rsp_tag_q       <= rsp_tag_d;
            rsp_result_q    <= rsp_result_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            div_operation_q <= div_operation_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_result    = rsp_result_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign div_operation = div_operation_q;
    assign div_valid     = div_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed testbench for div_share_ctrl. A behavioural divider with a
// programmable latency stands in for the shared division block.
module tb_div_share_ctrl;

    logic        CLK = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_dividend, req1_dividend, req0_divisor, req1_divisor;
    logic [1:0]  req0_op, req1_op;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_result;
    logic [31:0] div_dividend, div_divisor, div_result;
    logic [1:0]  div_operation;
    logic        div_valid, div_ready, busy;

    int checks   = 0;
    int failures = 0;
    int d_lat    = 3;
    int cnt      = 0;
    int stab_err = 0;
    logic [31:0] cap_a, cap_b;
    logic [1:0]  cap_op;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    always #5 CLK = ~CLK;

    div_share_ctrl #(.XLEN(32), .TAG_W(4)) dut (
        .CLK(CLK), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dividend(req0_dividend),
        .req0_divisor(req0_divisor), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dividend(req1_dividend),
        .req1_divisor(req1_divisor), .req1_op(req1_op), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_operation(div_operation), .div_valid(div_valid), .div_result(div_result),
        .div_ready(div_ready), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M reference used only by the stand-in divider.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   if (b == 32'd0) return 32'hFFFF_FFFF; else if (ovf) return a; else return $signed(a) / $signed(b);
            2'b01:   if (b == 32'd0) return 32'hFFFF_FFFF; else return a / b;
            2'b10:   if (b == 32'd0) return a; else if (ovf) return 32'd0; else return $signed(a) % $signed(b);
            default: if (b == 32'd0) return a; else return a % b;
        endcase
    endfunction

    // Stand-in divider: done pulse D cycles after the start pulse. It also watches operand stability.
    always @(negedge CLK) begin
        div_ready = 1'b0;
        if (div_valid) begin
            cnt    = d_lat;
            cap_a  = div_dividend;
            cap_b  = div_divisor;
            cap_op = div_operation;
        end else if (cnt > 0) begin
            if (div_dividend !== cap_a || div_divisor !== cap_b || div_operation !== cap_op) stab_err++;
            cnt--;
            if (cnt == 0) begin
                div_ready  = 1'b1;
                div_result = ref_div(cap_op, cap_a, cap_b);
            end
        end
    end

    task automatic set_req(input bit id, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        if (id) begin
            req1_valid = v; req1_op = op; req1_dividend = a; req1_divisor = b; req1_tag = tag;
        end else begin
            req0_valid = v; req0_op = op; req0_dividend = a; req0_divisor = b; req0_tag = tag;
        end
    endtask

    // Present a request, wait for its accept, and return at the negedge of cycle 1.
    task automatic issue(input bit id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input string name);
        int n;
        set_req(id, 1'b1, op, a, b, tag);
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 50) begin
            @(negedge CLK); #1; n++;
        end
        check_eq({name, "_accept"}, 32'(n < 50), 32'd1);
        @(negedge CLK);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Entered at the negedge of cycle 1. Measures the cycle in which rsp_valid appears.
    task automatic await_rsp(input string name, input int exp_lat, input int exp_dv,
                             input logic [31:0] exp_res, input logic exp_id, input logic [3:0] exp_tag);
        int lat;
        int dv;
        lat = 1;
        dv  = 0;
        while (!rsp_valid && lat < 60) begin
            if (div_valid) dv++;
            @(negedge CLK);
            lat++;
        end
        check_eq({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({name, "_divvalid"}, 32'(dv), 32'(exp_dv));
        check_eq({name, "_result"}, rsp_result, exp_res);
        check_eq({name, "_id"}, 32'(rsp_id), 32'(exp_id));
        check_eq({name, "_tag"}, 32'(rsp_tag), 32'(exp_tag));
        check_eq({name, "_stable"}, 32'(stab_err), 32'd0);
        stab_err = 0;
    endtask

    task automatic handshake(input string name);
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check_eq({name, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int bad;
        int k0;
        int k1;
        int n;
        int k;
        logic gid;
        rst = 1'b1; rsp_ready = 1'b0; div_ready = 1'b0; div_result = 32'd0;
        set_req(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge CLK);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_div_valid", 32'(div_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_div_dividend", div_dividend, 32'd0);
        check_eq("rst_rsp_result", rsp_result, 32'd0);
        rst = 1'b0;
        @(negedge CLK);

        // Basic divide and remainder with D = 3, so the response appears in cycle 5.
        issue(1'b0, OP_DIV, 32'd100, 32'd7, 4'd3, "div100");
        check_eq("busy_running", 32'(busy), 32'd1);
        await_rsp("div100", 5, 1, 32'd14, 1'b0, 4'd3);
        handshake("div100");
        issue(1'b0, OP_REMU, 32'd100, 32'd7, 4'd4, "remu100");
        await_rsp("remu100", 5, 1, 32'd2, 1'b0, 4'd4);
        handshake("remu100");

        // Signed operands from requester 1.
        issue(1'b1, OP_DIV, 32'hFFFF_FFEC, 32'd3, 4'd5, "divneg");
        await_rsp("divneg", 5, 1, 32'hFFFF_FFFA, 1'b1, 4'd5);
        handshake("divneg");
        issue(1'b1, OP_REM, 32'hFFFF_FFEC, 32'd3, 4'd6, "remneg");
        await_rsp("remneg", 5, 1, 32'hFFFF_FFFE, 1'b1, 4'd6);
        handshake("remneg");

        // Divide by zero and signed overflow.
        issue(1'b0, OP_DIV, 32'd5, 32'd0, 4'd7, "divzero");
`ifdef DIV_SPECIAL_CASE_EN
        await_rsp("divzero", 1, 0, 32'hFFFF_FFFF, 1'b0, 4'd7);
`else
        await_rsp("divzero", 5, 1, 32'hFFFF_FFFF, 1'b0, 4'd7);
`endif
        handshake("divzero");
        issue(1'b0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, "removf");
`ifdef DIV_SPECIAL_CASE_EN
        await_rsp("removf", 1, 0, 32'd0, 1'b0, 4'd8);
`else
        await_rsp("removf", 5, 1, 32'd0, 1'b0, 4'd8);
`endif
        handshake("removf");

        // Response stalled for 10 cycles while the other requester waits.
        issue(1'b0, OP_DIVU, 32'd50, 32'd5, 4'd9, "stall");
        await_rsp("stall", 5, 1, 32'd10, 1'b0, 4'd9);
        set_req(1'b1, 1'b1, OP_DIVU, 32'd9, 32'd3, 4'd10);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd10 || rsp_id !== 1'b0 || rsp_tag !== 4'd9 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || div_valid !== 1'b0) bad++;
            @(negedge CLK);
        end
        check_eq("stall_hold", 32'(bad), 32'd0);
        handshake("stall");
        issue(1'b1, OP_DIVU, 32'd9, 32'd3, 4'd10, "afterstall");
        await_rsp("afterstall", 5, 1, 32'd3, 1'b1, 4'd10);
        handshake("afterstall");

        // Reset during WAIT. The stale done pulse arrives two cycles later and must be ignored.
        d_lat = 6;
        issue(1'b0, OP_DIV, 32'd100, 32'd7, 4'd1, "rstwait");
        repeat (4) @(negedge CLK);
        check_eq("rstwait_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        check_eq("rstwait_busy_after", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge CLK);
        end
        check_eq("rstwait_no_rsp", 32'(bad), 32'd0);
        stab_err = 0;
        d_lat = 3;
        issue(1'b0, OP_DIV, 32'd100, 32'd7, 4'd2, "postrst");
        await_rsp("postrst", 5, 1, 32'd14, 1'b0, 4'd2);
        handshake("postrst");

        // Both requesters continuously valid: after reset the grants must alternate, starting with req0.
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        rsp_ready = 1'b1;
        k0 = 0;
        k1 = 0;
        set_req(1'b0, 1'b1, OP_DIVU, 32'd7, 32'd7, 4'd0);
        set_req(1'b1, 1'b1, OP_DIVU, 32'd10, 32'd7, 4'd8);
        for (int g = 0; g < 8; g++) begin
            #1;
            n = 0;
            while (!req0_ready && !req1_ready && n < 50) begin
                @(negedge CLK); #1; n++;
            end
            check_eq("alt_one_ready", 32'(req0_ready & req1_ready), 32'd0);
            gid = req1_ready;
            check_eq("alt_grant", 32'(gid), 32'(g % 2));
            k = gid ? k1 : k0;
            @(negedge CLK);
            if (gid) begin
                k1++;
                set_req(1'b1, k1 < 4, OP_DIVU, 32'(7 * (k1 + 1) + 3), 32'd7, 4'(8 + k1));
            end else begin
                k0++;
                set_req(1'b0, k0 < 4, OP_DIVU, 32'(7 * (k0 + 1)), 32'd7, 4'(k0));
            end
            await_rsp("alt", 5, 1, 32'(k + 1), gid, gid ? 4'(8 + k) : 4'(k));
            @(negedge CLK);
        end
        check_eq("alt_count0", 32'(k0), 32'd4);
        check_eq("alt_count1", 32'(k1), 32'd4);
        check_eq("alt_idle", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
